// File: rtl/ula_pkg.sv
// -----------------------------------------------------------------------------
// ula_pkg
// Shared types and constants for the ID/EX issue stage that feeds the 8-bit ULA.
//   DW          : datapath width (ULA SrcA/SrcB/ULAResult)
//   RW          : register-address width
//   ula_ctrl_t  : ULAControl encodings understood by the ULA
//   alu_op_t    : ALUOp encodings coming from the main decoder
//   id_ex_t     : packed ID/EX pipeline register contents
//   decode_ctrl : ALUOp/funct3/funct7 -> ULAControl mapping
// -----------------------------------------------------------------------------
package ula_pkg;

    localparam int DW = 8;
    localparam int RW = 5;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        SLT = 3'b101,
        ILL = 3'b111
    } ula_ctrl_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10,
        ALU_OP_RSVD  = 2'b11
    } alu_op_t;

    // A bubble is simply the all-zero value of this struct.
    typedef struct packed {
        logic            valid;
        ula_ctrl_t       alu_ctrl;
        logic            illegal;
        logic            reg_write;
        logic            alu_src;
        logic [RW-1:0]   rd;
        logic [RW-1:0]   rs1_addr;
        logic [RW-1:0]   rs2_addr;
        logic [DW-1:0]   rs1_data;
        logic [DW-1:0]   rs2_data;
        logic [DW-1:0]   imm;
    } id_ex_t;

    // Anything not explicitly supported decodes to ILL; the ULA returns 0 for it.
    function automatic ula_ctrl_t decode_ctrl(input logic [1:0] alu_op,
                                              input logic [2:0] funct3,
                                              input logic       op5,
                                              input logic       funct7b5);
        ula_ctrl_t ctrl;
        ctrl = ILL;
        case (alu_op)
            ALU_OP_ADD: ctrl = ADD;
            ALU_OP_SUB: ctrl = SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    3'b000:  ctrl = (op5 && funct7b5) ? SUB : ADD;
                    3'b010:  ctrl = SLT;
                    3'b110:  ctrl = OR;
                    3'b111:  ctrl = AND;
                    default: ctrl = ILL;
                endcase
            end
            default: ctrl = ILL;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/ula_fwd_mux.sv
// -----------------------------------------------------------------------------
// ula_fwd_mux
// Forwarding comparator and 3:1 operand mux for one source register.
//   src_addr        : registered source register number
//   rf_data         : registered register-file read data
//   exmem_*         : EX/MEM destination, write enable and result
//   memwb_*         : MEM/WB destination, write enable and writeback value
//   fwd_data        : selected operand (EX/MEM > MEM/WB > register file)
// x0 is never forwarded because a hit requires a non-zero destination.
// -----------------------------------------------------------------------------
module ula_fwd_mux
    import ula_pkg::*;
(
    input  logic [RW-1:0] src_addr,
    input  logic [DW-1:0] rf_data,
    input  logic [RW-1:0] exmem_rd,
    input  logic          exmem_reg_write,
    input  logic [DW-1:0] exmem_result,
    input  logic [RW-1:0] memwb_rd,
    input  logic          memwb_reg_write,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] fwd_data
);

    logic exmem_hit_s;
    logic memwb_hit_s;

    assign exmem_hit_s = exmem_reg_write && (exmem_rd != {RW{1'b0}}) && (exmem_rd == src_addr);
    assign memwb_hit_s = memwb_reg_write && (memwb_rd != {RW{1'b0}}) && (memwb_rd == src_addr);

    // Priority select: the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        fwd_data = rf_data;
        if (exmem_hit_s) begin
            fwd_data = exmem_result;
        end else if (memwb_hit_s) begin
            fwd_data = memwb_result;
        end else begin
            fwd_data = rf_data;
        end
    end

endmodule

// File: rtl/ula_issue.sv
// -----------------------------------------------------------------------------
// ula_issue
// ID/EX issue stage for the 8-bit ULA: decodes ALUOp/funct3/funct7 into
// ULAControl, registers operands and destination info, and forwards
// EX/MEM and MEM/WB results onto the registered source operands.
//   clk, rst             : pipeline clock, synchronous active-high reset
//   in_valid/stall/flush : decode-stage valid and hazard-unit controls
//   alu_op..reg_write    : decode-stage instruction fields
//   exmem_*, memwb_*     : forwarding sources
//   SrcA, SrcB           : ULA operands (forwarded, combinational)
//   ULAControl, illegal  : registered decode result
//   ex_valid, ex_rd, ex_reg_write, ex_store_data : carried-forward EX info
// Latency is one cycle from decode inputs to ULAControl/operands.
// -----------------------------------------------------------------------------
module ula_issue
    import ula_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          stall,
    input  logic          flush,
    input  logic [1:0]    alu_op,
    input  logic [2:0]    funct3,
    input  logic          funct7b5,
    input  logic          op5,
    input  logic          alu_src,
    input  logic [DW-1:0] rs1_data,
    input  logic [DW-1:0] rs2_data,
    input  logic [DW-1:0] imm,
    input  logic [RW-1:0] rs1_addr,
    input  logic [RW-1:0] rs2_addr,
    input  logic [RW-1:0] rd_addr,
    input  logic          reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic          exmem_reg_write,
    input  logic [DW-1:0] exmem_result,
    input  logic [RW-1:0] memwb_rd,
    input  logic          memwb_reg_write,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] SrcA,
    output logic [DW-1:0] SrcB,
    output logic [2:0]    ULAControl,
    output logic          ex_valid,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic [DW-1:0] ex_store_data,
    output logic          illegal
);

    id_ex_t        id_ex_r;
    id_ex_t        load_s;
    ula_ctrl_t     dec_ctrl_s;
    logic          dec_illegal_s;
    logic [DW-1:0] fwd_rs1_s;
    logic [DW-1:0] fwd_rs2_s;

    assign dec_ctrl_s    = decode_ctrl(alu_op, funct3, op5, funct7b5);
    assign dec_illegal_s = (dec_ctrl_s == ILL);

    // Build the value the ID/EX register takes when it is allowed to advance.
    always_comb begin
        load_s = '0;
        if (in_valid) begin
            load_s.valid     = 1'b1;
            load_s.alu_ctrl  = dec_ctrl_s;
            load_s.illegal   = dec_illegal_s;
            // An unsupported instruction must never commit a register write.
            load_s.reg_write = reg_write && !dec_illegal_s;
            load_s.alu_src   = alu_src;
            load_s.rd        = rd_addr;
            load_s.rs1_addr  = rs1_addr;
            load_s.rs2_addr  = rs2_addr;
            load_s.rs1_data  = rs1_data;
            load_s.rs2_data  = rs2_data;
            load_s.imm       = imm;
        end else begin
            load_s = '0;
        end
    end

    // ID/EX register: reset, then flush over stall, then load.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_r <= '0;
        end else if (flush) begin
            id_ex_r <= '0;
        end else if (stall) begin
            id_ex_r <= id_ex_r;
        end else begin
            id_ex_r <= load_s;
        end
    end

    ula_fwd_mux u_fwd_rs1 (
        .src_addr        (id_ex_r.rs1_addr),
        .rf_data         (id_ex_r.rs1_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs1_s)
    );

    ula_fwd_mux u_fwd_rs2 (
        .src_addr        (id_ex_r.rs2_addr),
        .rf_data         (id_ex_r.rs2_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs2_s)
    );

    assign SrcA          = fwd_rs1_s;
    assign SrcB          = id_ex_r.alu_src ? id_ex_r.imm : fwd_rs2_s;
    assign ex_store_data = fwd_rs2_s;
    assign ULAControl    = id_ex_r.alu_ctrl;
    assign ex_valid      = id_ex_r.valid;
    assign ex_rd         = id_ex_r.rd;
    assign ex_reg_write  = id_ex_r.reg_write;
    assign illegal       = id_ex_r.illegal;

endmodule

// File: tb/tb_ula_issue.sv
// -----------------------------------------------------------------------------
// tb_ula_issue
// Self-checking bench for ula_issue: a decode table, hand-written hazard and
// forwarding sequences, and randomized cycles checked against a reference
// model of the ID/EX register and forwarding rules.
// -----------------------------------------------------------------------------
module tb_ula_issue;

    logic       clk = 1'b0;
    logic       rst, in_valid, stall, flush;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic       funct7b5, op5, alu_src, reg_write;
    logic [7:0] rs1_data, rs2_data, imm;
    logic [4:0] rs1_addr, rs2_addr, rd_addr;
    logic [4:0] exmem_rd, memwb_rd;
    logic       exmem_reg_write, memwb_reg_write;
    logic [7:0] exmem_result, memwb_result;
    logic [7:0] srca, srcb, ex_store_data;
    logic [2:0] ula_control;
    logic       ex_valid, ex_reg_write, illegal;
    logic [4:0] ex_rd;

    int errors = 0;
    int checks = 0;

    // Reference model of what the EX stage currently holds.
    logic       m_valid, m_ill, m_rw, m_src;
    logic [2:0] m_ctrl;
    logic [4:0] m_rd, m_rs1a, m_rs2a;
    logic [7:0] m_rs1d, m_rs2d, m_imm;

    always #5 clk = ~clk;

    ula_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5), .op5(op5),
        .alu_src(alu_src), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .reg_write(reg_write), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_result(exmem_result), .memwb_rd(memwb_rd),
        .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .SrcA(srca), .SrcB(srcb), .ULAControl(ula_control), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_store_data(ex_store_data),
        .illegal(illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ULA code for an instruction; 3'b111 means unsupported.
    function automatic logic [2:0] ref_ctrl(input logic [1:0] op, input logic [2:0] f3,
                                            input logic o5, input logic f7);
        if (op == 2'd0) return 3'd0;
        if (op == 2'd1) return 3'd1;
        if (op == 2'd3) return 3'd7;
        if (f3 == 3'd0) return (o5 && f7) ? 3'd1 : 3'd0;
        if (f3 == 3'd2) return 3'd5;
        if (f3 == 3'd6) return 3'd3;
        if (f3 == 3'd7) return 3'd2;
        return 3'd7;
    endfunction

    function automatic logic [7:0] ref_fwd(input logic [4:0] a, input logic [7:0] rf);
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == a) return exmem_result;
        if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == a) return memwb_result;
        return rf;
    endfunction

    task automatic model_clear();
        m_valid = 1'b0; m_ill = 1'b0; m_rw = 1'b0; m_src = 1'b0; m_ctrl = 3'd0;
        m_rd = 5'd0; m_rs1a = 5'd0; m_rs2a = 5'd0;
        m_rs1d = 8'd0; m_rs2d = 8'd0; m_imm = 8'd0;
    endtask

    // Advance the model with the inputs present at the edge, then the DUT.
    task automatic tick();
        if (rst || flush || (!stall && !in_valid)) begin
            model_clear();
        end else if (!stall) begin
            m_valid = 1'b1;
            m_ctrl  = ref_ctrl(alu_op, funct3, op5, funct7b5);
            m_ill   = (m_ctrl == 3'd7);
            m_rw    = reg_write && !m_ill;
            m_src   = alu_src;
            m_rd    = rd_addr; m_rs1a = rs1_addr; m_rs2a = rs2_addr;
            m_rs1d  = rs1_data; m_rs2d = rs2_data; m_imm = imm;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] fa, fb;
        fa = ref_fwd(m_rs1a, m_rs1d);
        fb = ref_fwd(m_rs2a, m_rs2d);
        check({tag, ".SrcA"}, 32'(srca), 32'(fa));
        check({tag, ".SrcB"}, 32'(srcb), 32'(m_src ? m_imm : fb));
        check({tag, ".store"}, 32'(ex_store_data), 32'(fb));
        check({tag, ".ctrl"}, 32'(ula_control), 32'(m_ctrl));
        check({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
        check({tag, ".rd"}, 32'(ex_rd), 32'(m_rd));
        check({tag, ".rw"}, 32'(ex_reg_write), 32'(m_rw));
        check({tag, ".illegal"}, 32'(illegal), 32'(m_ill));
    endtask

    task automatic no_fwd();
        exmem_rd = 5'd0; exmem_reg_write = 1'b0; exmem_result = 8'd0;
        memwb_rd = 5'd0; memwb_reg_write = 1'b0; memwb_result = 8'd0;
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [2:0] f3, input logic o5,
                             input logic f7, input logic src, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] im);
        in_valid = 1'b1; reg_write = 1'b1; stall = 1'b0; flush = 1'b0;
        alu_op = op; funct3 = f3; op5 = o5; funct7b5 = f7; alu_src = src;
        rs1_data = a; rs2_data = b; imm = im;
        rs1_addr = 5'd1; rs2_addr = 5'd2; rd_addr = 5'd7;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic       o5, f7, src;
        logic [7:0] a, b, im;
        logic [2:0] e_ctrl;
        logic       e_ill;
        logic [7:0] e_srca, e_srcb;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 8'h0A, 8'h03, 8'h00, 3'b001, 1'b0, 8'h0A, 8'h03};
        vecs[1]  = '{2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 8'h0A, 8'h03, 8'h05, 3'b101, 1'b0, 8'h0A, 8'h05};
        vecs[2]  = '{2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 8'h0A, 8'h03, 8'h05, 3'b111, 1'b1, 8'h0A, 8'h05};
        vecs[3]  = '{2'b00, 3'b111, 1'b0, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 3'b000, 1'b0, 8'h11, 8'h22};
        vecs[4]  = '{2'b01, 3'b000, 1'b1, 1'b0, 1'b0, 8'h44, 8'h55, 8'h66, 3'b001, 1'b0, 8'h44, 8'h55};
        vecs[5]  = '{2'b11, 3'b000, 1'b0, 1'b0, 1'b1, 8'h01, 8'h02, 8'h9C, 3'b111, 1'b1, 8'h01, 8'h9C};
        vecs[6]  = '{2'b10, 3'b110, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h0F, 8'h00, 3'b011, 1'b0, 8'hF0, 8'h0F};
        vecs[7]  = '{2'b10, 3'b111, 1'b1, 1'b0, 1'b0, 8'hAA, 8'h55, 8'h00, 3'b010, 1'b0, 8'hAA, 8'h55};
        vecs[8]  = '{2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 8'h80, 8'h7F, 8'hFF, 3'b000, 1'b0, 8'h80, 8'hFF};
        vecs[9]  = '{2'b10, 3'b001, 1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h00, 3'b111, 1'b1, 8'h12, 8'h34};
        vecs[10] = '{2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 8'h03, 8'h04, 8'h00, 3'b000, 1'b0, 8'h03, 8'h04};

        // Reset state
        set_instr(2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 8'h0A, 8'h03, 8'h00);
        no_fwd();
        rst = 1'b1;
        model_clear();
        tick(); tick();
        check("reset.SrcA", 32'(srca), 32'h0);
        check("reset.SrcB", 32'(srcb), 32'h0);
        check("reset.ctrl", 32'(ula_control), 32'h0);
        check("reset.valid", 32'(ex_valid), 32'h0);
        check("reset.rw", 32'(ex_reg_write), 32'h0);
        check("reset.illegal", 32'(illegal), 32'h0);
        rst = 1'b0;

        // Decode table
        for (int i = 0; i < 11; i++) begin
            set_instr(vecs[i].op, vecs[i].f3, vecs[i].o5, vecs[i].f7, vecs[i].src,
                      vecs[i].a, vecs[i].b, vecs[i].im);
            tick();
            check($sformatf("vec%0d.ctrl", i), 32'(ula_control), 32'(vecs[i].e_ctrl));
            check($sformatf("vec%0d.illegal", i), 32'(illegal), 32'(vecs[i].e_ill));
            check($sformatf("vec%0d.rw", i), 32'(ex_reg_write), 32'(!vecs[i].e_ill));
            check($sformatf("vec%0d.SrcA", i), 32'(srca), 32'(vecs[i].e_srca));
            check($sformatf("vec%0d.SrcB", i), 32'(srcb), 32'(vecs[i].e_srcb));
            check($sformatf("vec%0d.valid", i), 32'(ex_valid), 32'h1);
        end

        // Forwarding priority and x0 exclusion
        set_instr(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 8'h11, 8'h22, 8'h00);
        rs1_addr = 5'd3; rs2_addr = 5'd4;
        tick();
        exmem_rd = 5'd3; exmem_reg_write = 1'b1; exmem_result = 8'h55;
        memwb_rd = 5'd3; memwb_reg_write = 1'b1; memwb_result = 8'h66;
        #1 check("fwd.exmem", 32'(srca), 32'h55);
        exmem_reg_write = 1'b0;
        #1 check("fwd.memwb", 32'(srca), 32'h66);
        memwb_rd = 5'd4;
        #1 check("fwd.rs2_srcb", 32'(srcb), 32'h66);
        check("fwd.rs2_store", 32'(ex_store_data), 32'h66);
        check("fwd.rs1_rf", 32'(srca), 32'h11);
        rs1_addr = 5'd0; rs1_data = 8'h77;
        exmem_rd = 5'd0; exmem_reg_write = 1'b1; memwb_rd = 5'd0;
        tick();
        check("fwd.x0", 32'(srca), 32'h77);
        no_fwd();

        // Stall holds, flush beats stall
        set_instr(2'b10, 3'b111, 1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h00);
        rd_addr = 5'd9;
        tick();
        funct3 = 3'b110; rs1_data = 8'hAB; rd_addr = 5'd2; stall = 1'b1;
        tick(); tick();
        check("stall.ctrl", 32'(ula_control), 32'h2);
        check("stall.SrcA", 32'(srca), 32'h12);
        check("stall.rd", 32'(ex_rd), 32'h9);
        flush = 1'b1;
        tick();
        check("flush.valid", 32'(ex_valid), 32'h0);
        check("flush.ctrl", 32'(ula_control), 32'h0);
        check("flush.rd", 32'(ex_rd), 32'h0);

        // Mid-stream reset, and nothing captured while rst is high
        set_instr(2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 8'h21, 8'h43, 8'h65);
        tick();
        check("prerst.valid", 32'(ex_valid), 32'h1);
        rst = 1'b1;
        tick();
        check_all("rst1");
        check("rst1.valid", 32'(ex_valid), 32'h0);
        set_instr(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 8'h99, 8'h88, 8'h77);
        tick();
        check("rst2.SrcA", 32'(srca), 32'h0);
        check("rst2.ctrl", 32'(ula_control), 32'h0);
        rst = 1'b0;

        // Invalid input slot becomes a bubble
        set_instr(2'b10, 3'b110, 1'b0, 1'b0, 1'b0, 8'h5A, 8'hA5, 8'h00);
        in_valid = 1'b0;
        tick();
        check("inv.valid", 32'(ex_valid), 32'h0);
        check("inv.rw", 32'(ex_reg_write), 32'h0);

        // Randomized cycles against the model
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 39) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            alu_op   = 2'($urandom);
            funct3   = 3'($urandom);
            op5      = 1'($urandom);
            funct7b5 = 1'($urandom);
            alu_src  = 1'($urandom);
            reg_write = 1'($urandom);
            rs1_data = 8'($urandom); rs2_data = 8'($urandom); imm = 8'($urandom);
            rs1_addr = 5'($urandom_range(0, 3));
            rs2_addr = 5'($urandom_range(0, 3));
            rd_addr  = 5'($urandom);
            exmem_rd = 5'($urandom_range(0, 3)); exmem_reg_write = 1'($urandom);
            exmem_result = 8'($urandom);
            memwb_rd = 5'($urandom_range(0, 3)); memwb_reg_write = 1'($urandom);
            memwb_result = 8'($urandom);
            tick();
            check_all("rnd");
            exmem_rd = 5'($urandom_range(0, 3)); exmem_reg_write = 1'($urandom);
            memwb_rd = 5'($urandom_range(0, 3)); memwb_reg_write = 1'($urandom);
            #1 check_all("rndfwd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
